// File: rtl/mu0_pkg.sv
// MU0 control: shared opcodes, ALU codes, state encoding and control vector.
package mu0_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned ALU_W = 2;
    localparam int unsigned ST_W  = 2;

    localparam logic [OP_W-1:0] OP_LDA = 4'd0;
    localparam logic [OP_W-1:0] OP_STA = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB = 4'd3;
    localparam logic [OP_W-1:0] OP_JMP = 4'd4;
    localparam logic [OP_W-1:0] OP_JGE = 4'd5;
    localparam logic [OP_W-1:0] OP_JNE = 4'd6;
    localparam logic [OP_W-1:0] OP_STP = 4'd7;

    localparam logic [ALU_W-1:0] ALU_ADD   = 2'd0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 2'd1;
    localparam logic [ALU_W-1:0] ALU_INC   = 2'd2;
    localparam logic [ALU_W-1:0] ALU_PASSY = 2'd3;

    typedef enum logic [ST_W-1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_t;

    // Full set of control lines driven toward the datapath
    typedef struct packed {
        logic             asel;
        logic             bsel;
        logic             xsel;
        logic             ysel;
        logic [ALU_W-1:0] alufs;
        logic             accce;
        logic             pcce;
        logic             irce;
        logic             accoe;
        logic             memrq;
        logic             rnw;
        logic             halted;
    } ctrl_t;

    // Opcodes that hold a memory access open until acknowledged
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB};
    endfunction

    // Single-cycle PC-update opcodes
    function automatic logic is_jump_op(input logic [OP_W-1:0] op);
        return op inside {OP_JMP, OP_JGE, OP_JNE};
    endfunction

endpackage

// File: rtl/mu0_control_if.sv
// MU0 control <-> datapath/memory signal bundle.
interface mu0_control_if;

    logic [mu0_pkg::OP_W-1:0]  F;
    logic                      N;
    logic                      Z;
    logic                      MEMack;
    logic                      Asel;
    logic                      Bsel;
    logic                      Xsel;
    logic                      Ysel;
    logic [mu0_pkg::ALU_W-1:0] ALUfs;
    logic                      ACCce;
    logic                      PCce;
    logic                      IRce;
    logic                      ACCoe;
    logic                      MEMrq;
    logic                      RnW;
    logic                      Halted;

    modport master (
        input  F, N, Z, MEMack,
        output Asel, Bsel, Xsel, Ysel, ALUfs, ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted
    );

    modport slave (
        output F, N, Z, MEMack,
        input  Asel, Bsel, Xsel, Ysel, ALUfs, ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted
    );

endinterface

// File: rtl/mu0_ctrl_decode.sv
// Purely combinational (state, opcode, flags, ack) to control-vector decoder.
module mu0_ctrl_decode
    import mu0_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    input  logic            n,
    input  logic            z,
    input  logic            mem_ack,
    output ctrl_t           ctrl
);

    // Everything defaults low so unused selects and ALU codes are never X
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memrq = 1'b1;
                ctrl.rnw   = 1'b1;
                ctrl.xsel  = 1'b1;
                ctrl.alufs = ALU_INC;
                ctrl.irce  = mem_ack;
                ctrl.pcce  = mem_ack;
            end
            EXECUTE: begin
                case (op)
                    OP_LDA: begin
                        ctrl.memrq = 1'b1;
                        ctrl.rnw   = 1'b1;
                        ctrl.asel  = 1'b1;
                        ctrl.bsel  = 1'b1;
                        ctrl.accce = mem_ack;
                    end
                    OP_STA: begin
                        ctrl.memrq = 1'b1;
                        ctrl.asel  = 1'b1;
                        ctrl.accoe = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.memrq = 1'b1;
                        ctrl.rnw   = 1'b1;
                        ctrl.asel  = 1'b1;
                        ctrl.alufs = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                        ctrl.accce = mem_ack;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        ctrl.ysel  = 1'b1;
                        ctrl.alufs = ALU_PASSY;
                        if (op == OP_JGE)      ctrl.pcce = ~n;
                        else if (op == OP_JNE) ctrl.pcce = ~z;
                        else                   ctrl.pcce = 1'b1;
                    end
                    default: ;
                endcase
            end
            HALT:    ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXECUTE/HALT sequencer driving datapath selects and enables.
module mu0_control
    import mu0_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    mu0_control_if.master bus
);

    state_t state;
    state_t state_nx;
    ctrl_t  ctrl_c;
    ctrl_t  ctrl_out;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nx;
    end

    // Next state: memory ops wait for ack, jumps and illegal ops take one cycle
    always_comb begin
        state_nx = state;
        case (state)
            FETCH: begin
                if (bus.MEMack) state_nx = EXECUTE;
            end
            EXECUTE: begin
                if (is_mem_op(bus.F)) begin
                    if (bus.MEMack) state_nx = FETCH;
                end else if (bus.F == OP_STP) begin
                    state_nx = HALT;
                end else if (is_jump_op(bus.F)) begin
                    state_nx = FETCH;
                end else begin
                    state_nx = HALT_ON_ILLEGAL ? HALT : FETCH;
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    mu0_ctrl_decode u_decode (
        .state   (state),
        .op      (bus.F),
        .n       (bus.N),
        .z       (bus.Z),
        .mem_ack (bus.MEMack),
        .ctrl    (ctrl_c)
    );

    // Reset kills every control line at once, abandoning any access in flight
    always_comb begin
        ctrl_out = '0;
        if (reset_n) ctrl_out = ctrl_c;
    end

    assign bus.Asel   = ctrl_out.asel;
    assign bus.Bsel   = ctrl_out.bsel;
    assign bus.Xsel   = ctrl_out.xsel;
    assign bus.Ysel   = ctrl_out.ysel;
    assign bus.ALUfs  = ctrl_out.alufs;
    assign bus.ACCce  = ctrl_out.accce;
    assign bus.PCce   = ctrl_out.pcce;
    assign bus.IRce   = ctrl_out.irce;
    assign bus.ACCoe  = ctrl_out.accoe;
    assign bus.MEMrq  = ctrl_out.memrq;
    assign bus.RnW    = ctrl_out.rnw;
    assign bus.Halted = ctrl_out.halted;

endmodule
